mul_share_sched: RTL and testbench
==================================

// Module: mul_share_sched
// PURPOSE
//  Shares one log/exact multiplier datapath between NREQ requesters (e.g. systolic PE columns).
//  Round-robin arbitration with valid/ready on the request side; valid-only (no backpressure) response.
//  Drives the multiplier operands and pip_en, tracks requester IDs through the fixed-latency
//  multiplier pipe and returns each product tagged with its requester ID. Supports a flush/drain sequence.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  WIDTH_A  16  operand A width
//  WIDTH_B  16  operand B width
//  WIDTH_MUL 32 product width
//  MUL_LAT  0   multiplier register stages between mul_a/mul_b and mul_out (0 = combinational)
//  IDW      2   requester ID width, clog2(NREQ)
// PORTS
//  clk         in   1              clock, all logic on rising edge
//  rst         in   1              synchronous reset, active-high
//  req_valid   in   NREQ           per-requester operand valid
//  req_ready   out  NREQ           per-requester grant; transfer when valid&ready
//  req_a       in   NREQ*WIDTH_A   packed operand A, requester i at [i*WIDTH_A +: WIDTH_A]
//  req_b       in   NREQ*WIDTH_B   packed operand B
//  flush       in   1              request drain; level, sampled every cycle
//  flush_done  out  1              1-cycle pulse: drain complete
//  mul_pip_en  out  1              multiplier pipeline enable
//  mul_a       out  WIDTH_A        multiplier operand A (registered)
//  mul_b       out  WIDTH_B        multiplier operand B (registered)
//  mul_out     in   WIDTH_MUL      multiplier product
//  resp_valid  out  1              product valid (1 cycle, no backpressure)
//  resp_id     out  IDW            requester ID of product
//  resp_data   out  WIDTH_MUL      product
//  busy        out  1              any op issued or in flight
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer=0; tag pipe cleared; FSM=IDLE. Reset mid-op discards in-flight ops, no resp.
//  Arbitration: at most one grant/cycle; search starts at (last_grant+1) mod NREQ, wraps. req_ready is
//   combinational from req_valid and state; requesters must not make valid depend on ready.
//   Pointer updates only on an accepted transfer.
//  Issue: accept in cycle t -> mul_a/mul_b/issue_v registered at t+1; id enters tag pipe (depth MUL_LAT+1).
//   Non-issue cycles hold mul_a/mul_b at the last value (issue_v=0).
//  Response: resp_valid/resp_id/resp_data registered at t+2+MUL_LAT (latency MUL_LAT+2; 2 when MUL_LAT=0).
//   Throughput 1 op/cycle; responses in issue order.
//  mul_pip_en=1 while busy or an accept occurs this cycle; 0 when pipe empty (idle gating).
//  inflight counter: +1 on accept, -1 on resp; width clog2(MUL_LAT+3); never overflows (bounded by pipe depth).
//  FSM: IDLE (no ops) -> RUN on first accept; RUN -> IDLE when inflight=0 and no accept;
//   IDLE/RUN -> DRAIN on flush=1; DRAIN: req_ready=0, in-flight ops complete normally;
//   DRAIN -> IDLE when inflight=0, flush_done pulses that cycle. Flush while IDLE: flush_done next cycle.
//  Simultaneous flush and req_valid: flush wins, no grant. flush held high after done: stays IDLE, no grants, no repeat pulse until flush drops.
//  Arithmetic: no sign handling here; products passed through unchanged.
// CONFIGURATION
//  MUL_SHARE_SCHED_PERF_EN defined: adds outputs perf_ops[31:0] (accepted ops) and perf_stall[31:0]
//   (cycles with any req_valid but no accept); both clear on rst, saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Single req0 A=3 B=5, MUL_LAT=0 -> resp_valid 2 cycles after accept, resp_id=0, resp_data=15.
//  All 4 req_valid held 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 responses in the same ID order, 1/cycle.
//  MUL_LAT=2, req1 and req3 back-to-back -> responses at accept+4 tagged 1 then 3, mul_pip_en high throughout.
//  flush asserted with 3 ops in flight and req_valid=4'b1111 -> req_ready=0, 3 resps delivered, flush_done 1 pulse, FSM IDLE.
//  rst asserted with 2 ops in flight -> no resp_valid afterwards, all outputs 0, next grant to req0.
//  PERF_EN: req2 blocked 5 cycles by flush then accepted -> perf_stall=5, perf_ops=1.

Source files
------------

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier between NREQ requesters.
// Define MUL_SHARE_SCHED_PERF_EN to add the perf_ops / perf_stall counter outputs.
module mul_share_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = 32,
  parameter int MUL_LAT   = 0,
  parameter int IDW       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH_A-1:0] req_a,
  input  logic [NREQ*WIDTH_B-1:0] req_b,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    mul_pip_en,
  output logic [WIDTH_A-1:0]      mul_a,
  output logic [WIDTH_B-1:0]      mul_b,
  input  logic [WIDTH_MUL-1:0]    mul_out,
  output logic                    resp_valid,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH_MUL-1:0]    resp_data,
  output logic                    busy
`ifdef MUL_SHARE_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall
`endif
);

  localparam int CW = $clog2(MUL_LAT + 3);
  localparam int TD = MUL_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           rr_q, rr_d;
  logic                     hold_q, hold_d;
  logic [CW-1:0]            inflight_q, inflight_d;
  logic [WIDTH_A-1:0]       mul_a_q, mul_a_d;
  logic [WIDTH_B-1:0]       mul_b_q, mul_b_d;
  logic [TD-1:0]            tag_v_q, tag_v_d;
  logic [TD-1:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [IDW-1:0]           resp_id_q, resp_id_d;
  logic [WIDTH_MUL-1:0]     resp_data_q, resp_data_d;

  logic                     accept;
  logic [IDW-1:0]           gnt_id;
  logic [NREQ-1:0]          grant;
  logic                     done_c;

  // Round-robin pick starting at rr_q; flush or draining blocks every grant.
  always_comb begin
    int idx;
    grant  = '0;
    gnt_id = '0;
    accept = 1'b0;
    idx    = 0;
    if (!rst && !flush && state_q != S_DRAIN) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_q) + k) % NREQ;
        if (!accept && req_valid[idx]) begin
          accept      = 1'b1;
          grant[idx]  = 1'b1;
          gnt_id      = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    if (accept) begin
      rr_d    = IDW'((int'(gnt_id) + 1) % NREQ);
      mul_a_d = req_a[int'(gnt_id)*WIDTH_A +: WIDTH_A];
      mul_b_d = req_b[int'(gnt_id)*WIDTH_B +: WIDTH_B];
    end
    for (int i = TD - 1; i > 0; i--) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    tag_v_d[0]  = accept;
    tag_id_d[0] = gnt_id;
    resp_valid_d = tag_v_q[TD-1];
    resp_id_d    = tag_v_q[TD-1] ? tag_id_q[TD-1] : '0;
    resp_data_d  = tag_v_q[TD-1] ? mul_out : '0;
    inflight_d   = inflight_q + CW'(accept) - CW'(tag_v_q[TD-1]);
  end

  // hold_q remembers a completed flush so a still-high flush does not re-trigger a drain.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (!flush) hold_d = 1'b0;
        if (flush && !hold_q) state_d = S_DRAIN;
        else if (accept) state_d = S_RUN;
        else if (inflight_q == '0) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
          hold_d  = flush;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      hold_q       <= 1'b0;
      inflight_q   <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      hold_q       <= hold_d;
      inflight_q   <= inflight_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = grant;
  assign flush_done = done_c && !rst;
  assign busy       = (inflight_q != '0);
  assign mul_pip_en = busy || accept;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

`ifdef MUL_SHARE_SCHED_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Both counters saturate instead of wrapping.
  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (accept && perf_ops_q != 32'hFFFF_FFFF) perf_ops_d = perf_ops_q + 32'd1;
    if (!accept && (|req_valid) && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Testbench: two schedulers (MUL_LAT 0 and 2) driven by identical stimulus and
// checked every cycle against a transaction-level model of grants, responses and flushes.
module tb_mul_share_sched;

  localparam int N  = 4;
  localparam int NC = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;

  logic [3:0]  rdy   [2];
  logic        fdone [2];
  logic        pen   [2];
  logic        busyo [2];
  logic        rv    [2];
  logic [1:0]  rid   [2];
  logic [31:0] rdata [2];
  logic [15:0] ma    [2];
  logic [15:0] mb    [2];
  logic [31:0] mout  [2];
`ifdef MUL_SHARE_SCHED_PERF_EN
  logic [31:0] pops   [2];
  logic [31:0] pstall [2];
`endif

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(4), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MUL(32), .MUL_LAT(0), .IDW(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_a(req_a), .req_b(req_b),
    .flush(flush), .flush_done(fdone[0]), .mul_pip_en(pen[0]), .mul_a(ma[0]), .mul_b(mb[0]),
    .mul_out(mout[0]), .resp_valid(rv[0]), .resp_id(rid[0]), .resp_data(rdata[0]), .busy(busyo[0])
`ifdef MUL_SHARE_SCHED_PERF_EN
    , .perf_ops(pops[0]), .perf_stall(pstall[0])
`endif
  );

  mul_share_sched #(.NREQ(4), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MUL(32), .MUL_LAT(2), .IDW(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_a(req_a), .req_b(req_b),
    .flush(flush), .flush_done(fdone[1]), .mul_pip_en(pen[1]), .mul_a(ma[1]), .mul_b(mb[1]),
    .mul_out(mout[1]), .resp_valid(rv[1]), .resp_id(rid[1]), .resp_data(rdata[1]), .busy(busyo[1])
`ifdef MUL_SHARE_SCHED_PERF_EN
    , .perf_ops(pops[1]), .perf_stall(pstall[1])
`endif
  );

  // Multiplier stand-ins: combinational for dut0, two enabled register stages for dut2.
  logic [31:0] mp0, mp1;
  assign mout[0] = 32'(ma[0]) * 32'(mb[0]);
  always @(posedge clk) begin
    if (pen[1]) begin
      mp0 <= 32'(ma[1]) * 32'(mb[1]);
      mp1 <= mp0;
    end
  end
  assign mout[1] = mp1;

  int          lat [2] = '{0, 2};
  bit          accV [2][NC];
  int          accId [2][NC];
  logic [15:0] accA [2][NC];
  logic [15:0] accB [2][NC];
  int          ptr [2];
  bit          mDrain [2];
  bit          mHold [2];
  logic [15:0] lastA [2];
  logic [15:0] lastB [2];
  int unsigned pOps [2];
  int unsigned pStall [2];
  int          resetEnd = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", tag, k, cyc, obs, expv);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive at negedge, compare after settling, then advance the model.
  task automatic applyStimulus(input logic [3:0] v, input logic f, input logic r,
                               input logic [63:0] a, input logic [63:0] b);
    int bcnt, g, respT, id;
    logic [3:0] er;
    logic ed, erv;
    @(negedge clk);
    req_valid = v;
    flush     = f;
    rst       = r;
    req_a     = a;
    req_b     = b;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        accV[k][cyc] = 1'b0;
        mDrain[k] = 1'b0;
        mHold[k]  = 1'b0;
        ptr[k]    = 0;
        lastA[k]  = '0;
        lastB[k]  = '0;
        pOps[k]   = 0;
        pStall[k] = 0;
      end else begin
        bcnt = 0;
        for (int t = cyc - 1 - lat[k]; t <= cyc - 1; t++)
          if (t >= resetEnd && t >= 0 && accV[k][t]) bcnt++;
        respT = cyc - 2 - lat[k];
        erv = (respT >= resetEnd) && (respT >= 0) && accV[k][respT];
        er = '0;
        ed = 1'b0;
        g  = -1;
        if (mDrain[k]) begin
          if (bcnt == 0) begin
            ed = 1'b1;
            mDrain[k] = 1'b0;
            mHold[k]  = f;
          end
        end else if (f) begin
          if (!mHold[k]) mDrain[k] = 1'b1;
        end else begin
          mHold[k] = 1'b0;
          for (int j = 0; j < N; j++) begin
            id = (ptr[k] + j) % N;
            if (g < 0 && v[id]) g = id;
          end
          if (g >= 0) er[g] = 1'b1;
        end
        checkOutput("req_ready", k, 32'(rdy[k]), 32'(er));
        checkOutput("flush_done", k, 32'(fdone[k]), 32'(ed));
        checkOutput("mul_pip_en", k, 32'(pen[k]), 32'((bcnt > 0) || (g >= 0)));
        checkOutput("busy", k, 32'(busyo[k]), 32'(bcnt > 0));
        checkOutput("resp_valid", k, 32'(rv[k]), 32'(erv));
        if (erv) begin
          checkOutput("resp_id", k, 32'(rid[k]), 32'(accId[k][respT]));
          checkOutput("resp_data", k, rdata[k], 32'(accA[k][respT]) * 32'(accB[k][respT]));
        end
        checkOutput("mul_a", k, 32'(ma[k]), 32'(lastA[k]));
        checkOutput("mul_b", k, 32'(mb[k]), 32'(lastB[k]));
`ifdef MUL_SHARE_SCHED_PERF_EN
        checkOutput("perf_ops", k, pops[k], pOps[k]);
        checkOutput("perf_stall", k, pstall[k], pStall[k]);
`endif
        accV[k][cyc] = (g >= 0);
        if (g >= 0) begin
          accId[k][cyc] = g;
          accA[k][cyc]  = a[g*16 +: 16];
          accB[k][cyc]  = b[g*16 +: 16];
          lastA[k]      = a[g*16 +: 16];
          lastB[k]      = b[g*16 +: 16];
          ptr[k]        = (g + 1) % N;
          if (pOps[k] != 32'hFFFF_FFFF) pOps[k]++;
        end else if (|v) begin
          if (pStall[k] != 32'hFFFF_FFFF) pStall[k]++;
        end
      end
    end
    if (r) resetEnd = cyc + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0, rnd64(), rnd64());
  endtask

  initial begin
    logic fr;
    $display("[TB] start");
    applyStimulus(4'b0000, 1'b0, 1'b1, '0, '0);
    applyStimulus(4'b0000, 1'b0, 1'b1, '0, '0);
    idle(2);

    // Single request: 3 * 5 from requester 0.
    applyStimulus(4'b0001, 1'b0, 1'b0, 64'd3, 64'd5);
    idle(5);

    // All requesters valid for 8 cycles.
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b0, 1'b0, rnd64(), rnd64());
    idle(6);

    // Requester 1 then requester 3 back-to-back.
    applyStimulus(4'b0010, 1'b0, 1'b0, rnd64(), rnd64());
    applyStimulus(4'b1000, 1'b0, 1'b0, rnd64(), rnd64());
    idle(6);

    // Flush with ops in flight and everyone requesting; flush held after completion.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, 1'b0, rnd64(), rnd64());
    for (int i = 0; i < 9; i++) applyStimulus(4'b1111, 1'b1, 1'b0, rnd64(), rnd64());
    idle(2);
    for (int i = 0; i < 2; i++) applyStimulus(4'b1111, 1'b0, 1'b0, rnd64(), rnd64());
    idle(5);

    // Flush while idle.
    applyStimulus(4'b0000, 1'b1, 1'b0, rnd64(), rnd64());
    idle(3);

    // Reset with ops in flight, then the next grant starts from requester 0.
    for (int i = 0; i < 2; i++) applyStimulus(4'b1111, 1'b0, 1'b0, rnd64(), rnd64());
    applyStimulus(4'b1111, 1'b0, 1'b1, rnd64(), rnd64());
    idle(3);
    applyStimulus(4'b1111, 1'b0, 1'b0, rnd64(), rnd64());
    idle(5);

    // Requester 2 blocked by flush for 5 cycles, then accepted.
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 1'b1, 1'b0, rnd64(), rnd64());
    applyStimulus(4'b0100, 1'b0, 1'b0, rnd64(), rnd64());
    idle(5);

    // Random traffic with occasional flush bursts and resets.
    fr = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) fr = ~fr;
      applyStimulus(4'($urandom), fr, ($urandom_range(0, 99) == 0), rnd64(), rnd64());
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
